// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: pops WIDTH-bit entries from an async FIFO read port and
// packs RATIO of them little-endian into one output word on a valid/ready
// stream. A flush pulse drains a partial word with a keep mask and last flag.
module fifo_rd_packer #(
  parameter int WIDTH = 8,
  parameter int RATIO = 4
) (
  input  logic                     r_clk,
  input  logic                     rst_r,
  input  logic                     fifo_empty,
  output logic                     fifo_r_en,
  input  logic [WIDTH-1:0]         fifo_r_data,
  input  logic                     flush,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [WIDTH*RATIO-1:0]   m_data,
  output logic [RATIO-1:0]         m_keep,
  output logic                     m_last,
  output logic                     busy
);

  // byte_cnt must be able to hold RATIO (a full word parked in the accumulator)
  localparam int CW = $clog2(RATIO + 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(RATIO);
  localparam logic [CW-1:0] LAST_SLOT = CW'(RATIO - 1);

  logic [WIDTH*RATIO-1:0] acc_reg;
  logic [WIDTH*RATIO-1:0] acc_next;
  logic [WIDTH*RATIO-1:0] load_data;
  logic [CW-1:0]          byte_cnt_reg;
  logic [CW-1:0]          byte_cnt_next;
  logic [CW-1:0]          keep_cnt;
  logic [RATIO-1:0]       keep_mask;
  logic                   inflight_reg;
  logic                   flush_pending_reg;
  logic                   flush_pending_next;
  logic                   out_free;
  logic                   load;
  logic                   load_last;
  logic                   pend_clear;

  // Returning entry is merged into its slot; the keep mask zeroes unused slots
  // so stale entries from earlier words never leak into a partial word.
  for (genvar gi = 0; gi < RATIO; gi++) begin : g_slot
    assign acc_next[gi*WIDTH +: WIDTH] =
      (inflight_reg && (byte_cnt_reg == CW'(gi))) ? fifo_r_data : acc_reg[gi*WIDTH +: WIDTH];
    assign keep_mask[gi] = (CW'(gi) < keep_cnt);
    assign load_data[gi*WIDTH +: WIDTH] = keep_mask[gi] ? acc_next[gi*WIDTH +: WIDTH] : '0;
  end

  // Pop only when the accumulator can absorb the entry, including any in flight
  assign fifo_r_en = !rst_r && !fifo_empty && !flush_pending_reg &&
                     (({1'b0, byte_cnt_reg} + {{CW{1'b0}}, inflight_reg}) < (CW+1)'(RATIO));

  assign busy = (byte_cnt_reg != '0) | inflight_reg | m_valid | flush_pending_reg;

  // Decide whether the output register loads this cycle and how byte_cnt moves
  always_comb begin
    out_free      = !m_valid || m_ready;
    load          = 1'b0;
    load_last     = 1'b0;
    pend_clear    = 1'b0;
    keep_cnt      = byte_cnt_reg;
    byte_cnt_next = byte_cnt_reg;
    if (inflight_reg) begin
      if (byte_cnt_reg == LAST_SLOT) begin
        if (out_free) begin
          // Word completes straight into the output register
          load          = 1'b1;
          load_last     = flush_pending_reg;
          pend_clear    = flush_pending_reg;
          keep_cnt      = FULL_CNT;
          byte_cnt_next = '0;
        end else begin
          // Output busy: park the complete word and stop popping
          byte_cnt_next = FULL_CNT;
        end
      end else begin
        byte_cnt_next = byte_cnt_reg + CW'(1);
      end
    end else if (byte_cnt_reg == FULL_CNT) begin
      if (out_free) begin
        load          = 1'b1;
        load_last     = flush_pending_reg;
        pend_clear    = flush_pending_reg;
        byte_cnt_next = '0;
      end
    end else if (flush_pending_reg) begin
      if (byte_cnt_reg == '0) begin
        pend_clear = 1'b1;
      end else if (out_free) begin
        load          = 1'b1;
        load_last     = 1'b1;
        pend_clear    = 1'b1;
        byte_cnt_next = '0;
      end
    end
  end

  // A flush arriving while one is already pending is dropped
  always_comb begin
    flush_pending_next = flush_pending_reg;
    if (flush_pending_reg) begin
      flush_pending_next = !pend_clear;
    end else begin
      flush_pending_next = flush;
    end
  end

  // State and output registers
  always_ff @(posedge r_clk) begin
    if (rst_r) begin
      acc_reg           <= '0;
      byte_cnt_reg      <= '0;
      inflight_reg      <= 1'b0;
      flush_pending_reg <= 1'b0;
      m_valid           <= 1'b0;
      m_data            <= '0;
      m_keep            <= '0;
      m_last            <= 1'b0;
    end else begin
      acc_reg           <= acc_next;
      byte_cnt_reg      <= byte_cnt_next;
      inflight_reg      <= fifo_r_en;
      flush_pending_reg <= flush_pending_next;
      if (load) begin
        m_valid <= 1'b1;
        m_data  <= load_data;
        m_keep  <= keep_mask;
        m_last  <= load_last;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule
